// File: rtl/sift_ori_pkg.sv
// sift_ori_pkg: shared widths, FSM states and saturating add for orientation histograms.
package sift_ori_pkg;
    localparam int NBIN  = 32;
    localparam int DIR_W = 5;
    localparam int MAG_W = 8;
    localparam int ACC_W = 16;
    typedef enum logic [2:0] {IDLE, CLR, ACC, SCAN, DONE} state_t;
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [MAG_W-1:0] m);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W+1-MAG_W){1'b0}}, m};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction
endpackage

// File: rtl/ori_argmax.sv
// ori_argmax: sequential strict-greater max/arg tracker; ties keep the earliest index.
module ori_argmax import sift_ori_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIR_W-1:0] idx,
    input  logic [ACC_W-1:0] val,
    output logic [ACC_W-1:0] max,
    output logic [DIR_W-1:0] arg
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            max <= '0;
            arg <= '0;
        end else if (en && val > max) begin
            max <= val;
            arg <= idx;
        end
    end
endmodule

// File: rtl/ori_hist_acc.sv
// ori_hist_acc: per-keypoint 32-bin orientation histogram with sequential peak scan.
module ori_hist_acc import sift_ori_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIR_W-1:0] in_dir,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_last,
    output logic             busy,
    output logic             out_valid,
    output logic [DIR_W-1:0] out_bin,
    output logic [ACC_W-1:0] out_peak
);
    state_t           state;
    logic [ACC_W-1:0] hist [NBIN];
    logic [DIR_W-1:0] k, arg, bin_q;
    logic [ACC_W-1:0] max, peak_q;
    assign in_ready  = state == ACC;
    assign busy      = state != IDLE;
    assign out_valid = state == DONE;
    // arg/max settle on the last SCAN edge, so DONE shows them directly while the hold registers load
    assign out_bin   = out_valid ? arg : bin_q;
    assign out_peak  = out_valid ? max : peak_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            bin_q  <= '0;
            peak_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= CLR;
                CLR: begin
                    state <= ACC;
                    k     <= '0;
                end
                ACC: if (in_valid && in_last) state <= SCAN;
                SCAN: begin
                    k <= k + 1'b1;
                    if (k == DIR_W'(NBIN-1)) state <= DONE;
                end
                DONE: begin
                    state  <= IDLE;
                    bin_q  <= arg;
                    peak_q <= max;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBIN; i++) begin
            if (rst || state == CLR) hist[i] <= '0;
            else if (state == ACC && in_valid && in_dir == DIR_W'(i)) hist[i] <= sat_add(hist[i], in_mag);
        end
    end
    ori_argmax u_argmax (
        .clk(clk),
        .rst(rst),
        .clr(state == CLR),
        .en (state == SCAN),
        .idx(k),
        .val(hist[k]),
        .max(max),
        .arg(arg)
    );
endmodule

// File: tb/tb_ori_hist_acc.sv
// tb_ori_hist_acc: timeline-based reference model plus directed keypoint scenarios.
module tb_ori_hist_acc;
    localparam int BIG = 1 << 30;
    logic        clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
    logic [4:0]  in_dir = '0;
    logic [7:0]  in_mag = '0;
    logic        in_ready, busy, out_valid;
    logic [4:0]  out_bin;
    logic [15:0] out_peak;
    int pass_cnt = 0, chk_cnt = 0;
    int cur = 0, armed = 0;
    int busy_from = BIG, idle_at = 0, acc_from = BIG, done_at = -1, last_t = -1;
    bit in_acc = 0;
    int hist_m [32];
    int nxt_bin = 0, nxt_peak = 0, hold_bin = 0, hold_peak = 0;
    int b, p, t, s;

    ori_hist_acc dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_dir(in_dir), .in_mag(in_mag), .in_last(in_last), .busy(busy),
        .out_valid(out_valid), .out_bin(out_bin), .out_peak(out_peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: cur is the index of the cycle whose inputs were just sampled
    initial forever begin
        @(posedge clk);
        cur++;
        if (rst) begin
            armed = 1;
            busy_from = BIG; idle_at = 0; acc_from = BIG; done_at = -1;
            in_acc = 0; hold_bin = 0; hold_peak = 0;
            foreach (hist_m[i]) hist_m[i] = 0;
        end else begin
            if ((cur < busy_from || cur >= idle_at) && start) begin
                busy_from = cur + 1; idle_at = BIG; acc_from = cur + 2; in_acc = 1;
                foreach (hist_m[i]) hist_m[i] = 0;
            end else if (in_acc && cur >= acc_from && in_valid) begin
                hist_m[in_dir] = (hist_m[in_dir] + in_mag > 65535) ? 65535 : hist_m[in_dir] + in_mag;
                if (in_last) begin
                    in_acc = 0; last_t = cur; done_at = cur + 33; idle_at = cur + 34;
                    nxt_bin = 0; nxt_peak = 0;
                    for (int i = 0; i < 32; i++)
                        if (hist_m[i] > nxt_peak) begin nxt_peak = hist_m[i]; nxt_bin = i; end
                end
            end
            if (cur + 1 == done_at) begin hold_bin = nxt_bin; hold_peak = nxt_peak; end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("in_ready", int'(in_ready), int'(in_acc && cur + 1 >= acc_from));
            chk("busy", int'(busy), int'(!(cur + 1 < busy_from || cur + 1 >= idle_at)));
            chk("out_valid", int'(out_valid), int'(cur + 1 == done_at));
            chk("out_bin", int'(out_bin), hold_bin);
            chk("out_peak", int'(out_peak), hold_peak);
        end
    end

    task automatic do_start(output int sc);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        sc = cur;
    endtask

    task automatic send(input int d, input int m, input bit l);
        int n = 0;
        in_valid = 1; in_dir = d[4:0]; in_mag = m[7:0]; in_last = l;
        do begin @(negedge clk); n++; end while (!in_ready && n < 100);
        if (!in_ready) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int ob, output int op, output int ot);
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 200);
        chk("done_timeout", int'(out_valid), 1);
        ob = out_bin; op = out_peak; ot = cur + 1;
        @(posedge clk); #1;
    endtask

    initial begin
        gap(2);
        rst = 0;
        @(negedge clk);
        chk("rst_outputs", {in_ready, busy, out_valid, out_bin, out_peak}, 0);
        @(posedge clk); #1;
        do_start(s);
        send(5, 10, 0); send(5, 20, 0); send(9, 25, 1);
        wait_done(b, p, t);
        chk("basic_bin", b, 5); chk("basic_peak", p, 30); chk("basic_latency", t - last_t, 33);
        do_start(s);
        send(3, 40, 0); send(30, 40, 1);
        wait_done(b, p, t);
        chk("tie_bin", b, 3); chk("tie_peak", p, 40);
        do_start(s);
        send(0, 0, 1);
        wait_done(b, p, t);
        chk("empty_bin", b, 0); chk("empty_peak", p, 0); chk("turnaround", t - s, 35);
        do_start(s);
        for (int i = 0; i < 300; i++) send(31, 255, i == 299);
        wait_done(b, p, t);
        chk("sat_bin", b, 31); chk("sat_peak", p, 65535);
        do_start(s);
        send(4, 2, 0); gap($urandom_range(0, 3));
        send(12, 1, 0); send(12, 2, 0); send(12, 3, 0);
        gap($urandom_range(1, 3));
        start = 1; gap(1); start = 0;
        send(20, 5, 0); gap($urandom_range(0, 3));
        send(4, 3, 0); send(25, 1, 1);
        gap(5);
        start = 1; gap(1); start = 0;
        wait_done(b, p, t);
        chk("b2b_bin", b, 12); chk("b2b_peak", p, 6);
        do_start(s);
        send(2, 50, 1);
        gap(10);
        rst = 1; gap(1); rst = 0;
        @(negedge clk);
        chk("midscan_rst_outputs", {in_ready, busy, out_valid, out_bin, out_peak}, 0);
        @(posedge clk); #1;
        do_start(s);
        send(7, 1, 1);
        wait_done(b, p, t);
        chk("post_rst_bin", b, 7); chk("post_rst_peak", p, 1);
        gap(3);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ori_hist_acc.md
# ori_hist_acc

Orientation-histogram accumulator for SIFT keypoint orientation assignment. Sits directly downstream of the distributed direction ROMs, which map quantized gradients to 5-bit orientation bins. For each keypoint it accumulates gradient magnitudes into a 32-bin histogram, then scans the histogram sequentially. It reports the dominant bin and its peak value to the descriptor stage.

## Interface
- NBIN, 32, number of orientation bins; equals 2^DIR_W.
- DIR_W, 5, bin index width; matches the ROM `spo` width.
- MAG_W, 8, gradient magnitude width.
- ACC_W, 16, per-bin accumulator width.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new keypoint; accepted only in IDLE.
- in_valid  in  1  sample valid.
- in_ready  out  1  high only in ACC.
- in_dir  in  DIR_W  orientation bin from the direction ROM.
- in_mag  in  MAG_W  gradient magnitude.
- in_last  in  1  marks the final sample of the window; qualified by in_valid & in_ready.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  one-cycle pulse when the result is ready.
- out_bin  out  DIR_W  dominant bin; held until the next out_valid.
- out_peak  out  ACC_W  accumulated value of out_bin; held until the next out_valid.

## Operation
- States and transitions:
  - IDLE: start=1 → CLR.
  - CLR: zero all NBIN bins in one cycle → ACC.
  - ACC: in_valid & in_last accepted → SCAN.
  - SCAN: runs NBIN cycles → DONE.
  - DONE: → IDLE.
- ACC accept rule: on each in_valid & in_ready cycle, hist[in_dir] ← sat(hist[in_dir] + in_mag).
  - Saturation clamps at 2^ACC_W−1.
  - The sample carrying in_last is accumulated.
  - in_valid=0 cycles are stalls, with no limit on stall length.
- SCAN: index k runs 0..NBIN−1, one bin per cycle.
  - max and arg are registered.
  - Update only when hist[k] > max (strict), so ties resolve to the lowest index.
  - max initialises to 0 and arg to 0, so an all-zero histogram gives out_bin=0, out_peak=0.
- DONE: load out_bin/out_peak from arg/max, pulse out_valid, return to IDLE.
- start is ignored outside IDLE. start is also ignored in the cycle out_valid is high, since the FSM is in DONE that cycle.
- Bins wrap naturally: the in_dir full range 0..31 is valid, and no modulo arithmetic is required here (the ROM already wraps 0x1f→0x00).
- rst behaviour, in any state including mid-ACC and mid-SCAN:
  - state ← IDLE.
  - Histogram, k, max and arg cleared.
  - in_ready=0, busy=0, out_valid=0, out_bin=0, out_peak=0.

## Timing
- Reset values: every output is 0.
- start sampled at cycle S:
  - CLR at S+1.
  - ACC from S+2, with in_ready=1 from S+2.
- Accumulation: single-cycle read-modify-write.
  - Back-to-back samples to the same bin in consecutive cycles must both count; forward the written value or use register bins.
- in_last accepted at cycle T:
  - in_ready=0 from T+1.
  - SCAN during T+1..T+NBIN.
  - DONE and out_valid=1 at T+NBIN+1.
  - busy=0 and IDLE at T+NBIN+2.
- Minimum turnaround: start → out_valid is NBIN+3 cycles with a single in_last sample.
- out_bin/out_peak change only on the cycle where out_valid=1.

## Structure
- Shared package `sift_ori_pkg` holds:
  - NBIN, DIR_W, MAG_W, ACC_W defaults.
  - State enum {IDLE, CLR, ACC, SCAN, DONE}.
  - A saturating-add function.
- Histogram storage is NBIN×ACC_W flops, needed for the one-cycle CLR and forwarding-free RMW.
- One sub-module: `ori_argmax`, the sequential strict-greater max/arg tracker.
  - Ports: clk, rst, clr, en, idx, val; outputs max, arg.
  - Reused later for secondary-peak detection.

## Test plan
- Basic peak: start; samples (dir 5, mag 10), (dir 5, mag 20), (dir 9, mag 25, last) → out_valid with out_bin=5, out_peak=30, exactly NBIN+1 cycles after last.
- Tie and empty:
  - (dir 3, mag 40), (dir 30, mag 40, last) → out_bin=3, out_peak=40.
  - A single (dir 0, mag 0, last) → out_bin=0, out_peak=0.
- Saturation: 300 samples (dir 31, mag 255) with last on the final one → out_bin=31, out_peak=65535.
- Back-to-back and stalls:
  - Consecutive-cycle samples to dir 12 (mag 1,2,3) with random in_valid gaps between others → out_peak=6 for bin 12.
  - in_ready=0 outside ACC.
  - start pulses during ACC/SCAN are ignored.
- Reset mid-operation:
  - Assert rst during SCAN → all outputs 0 next cycle.
  - A new keypoint (dir 7, mag 1, last) → out_bin=7, out_peak=1, with no residue from the aborted histogram.
